// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Column-scan sequencer for a 4x4 active-low matrix keypad. It drives one
//   column low at a time and samples the rows once per column dwell. Both
//   press and release are debounced. It emits one key_valid pulse per
//   accepted press and freezes on that key's column until the key is released.
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   rows_n     [3:0] synchronized keypad rows, active-low (0 = pressed)
//   cols_n     [3:0] column drive, active-low, one-cold
//   key_code   [3:0] {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle pulse, key_code valid in the same cycle
//   key_held   high from acceptance until the release debounce completes
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV        = 15,
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_next;
  logic [1:0]       col_idx, col_next;
  logic [1:0]       row_idx, row_next;
  logic [3:0]       pattern, pattern_next;
  logic [CNT_W-1:0] dwell_cnt, dwell_next;
  logic [CNT_W-1:0] db_cnt, db_next;
  logic [3:0]       key_code_next;
  logic             key_valid_next;
  logic             key_held_next;

  // Row decode: number of low rows and the index of the (last) low row.
  logic [2:0] low_cnt;
  logic [1:0] low_row;

  always_comb begin
    low_cnt = '0;
    low_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows_n[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = 2'(i);
      end
    end
  end

  always_comb begin
    state_next     = state;
    col_next       = col_idx;
    row_next       = row_idx;
    pattern_next   = pattern;
    dwell_next     = dwell_cnt;
    db_next        = db_cnt;
    key_code_next  = key_code;
    key_valid_next = 1'b0;
    key_held_next  = key_held;

    unique case (state)
      SCAN: begin
        if (dwell_cnt >= DWELL_LAST) begin
          dwell_next = '0;
          if (low_cnt == 3'd1) begin
            pattern_next = rows_n;
            row_next     = low_row;
            db_next      = '0;
            state_next   = DEBOUNCE;
          end else begin
            // Idle or ambiguous (multi-key) sample: keep scanning.
            col_next = col_idx + 2'd1;
          end
        end else begin
          dwell_next = dwell_cnt + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        // The counter reaching the limit is what accepts the key; the
        // accept cycle itself does not re-check the rows.
        if (db_cnt >= DB_LAST) begin
          key_valid_next = 1'b1;
          key_code_next  = {row_idx, col_idx};
          key_held_next  = 1'b1;
          db_next        = '0;
          state_next     = HELD;
        end else if (rows_n == pattern) begin
          db_next = db_cnt + CNT_ONE;
        end else begin
          dwell_next = '0;
          db_next    = '0;
          state_next = SCAN;
        end
      end

      HELD: begin
        if (rows_n[row_idx]) begin
          db_next    = '0;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        if (!rows_n[row_idx]) begin
          db_next    = '0;
          state_next = HELD;
        end else if (db_cnt >= DB_LAST) begin
          key_held_next = 1'b0;
          col_next      = col_idx + 2'd1;
          dwell_next    = '0;
          db_next       = '0;
          state_next    = SCAN;
        end else begin
          db_next = db_cnt + CNT_ONE;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      pattern   <= '1;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      cols_n    <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_next;
      row_idx   <= row_next;
      pattern   <= pattern_next;
      dwell_cnt <= dwell_next;
      db_cnt    <= db_next;
      // Registered copy of the column decode, kept in step with col_idx.
      cols_n    <= ~(4'b0001 << col_next);
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
      key_held  <= key_held_next;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
//   Directed bench for keypad_scan_ctrl (SCAN_DIV=2, DEBOUNCE_CYCLES=4).
//   A behavioural model tracks the expected outputs every cycle; directed
//   steps also pin literal values.
module tb_keypad_scan_ctrl;

  localparam int SD = 2;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows_n = 4'hF;
  logic [3:0] cols_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scan_ctrl #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows_n(rows_n),
    .cols_n(cols_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Behavioural model. mode: 0 scanning, 1 confirming press,
  // 2 key down, 3 confirming release.
  int         m_mode = 0;
  int         m_col = 0;
  int         m_row = 0;
  int         m_dwell = 0;
  int         m_stable = 0;
  logic [3:0] m_pat = 4'hF;
  logic [3:0] m_code = 4'h0;
  bit         m_valid = 0;
  bit         m_held = 0;
  bit         m_live = 0;

  always @(posedge clk) begin : model
    int zeros;
    int idx;
    zeros = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (rows_n[i] == 1'b0) begin
        zeros++;
        idx = i;
      end
    end
    if (!reset) begin
      m_mode = 0; m_col = 0; m_row = 0; m_dwell = 0; m_stable = 0;
      m_pat = 4'hF; m_code = 4'h0; m_valid = 0; m_held = 0; m_live = 1;
    end else begin
      m_valid = 0;
      case (m_mode)
        0: begin
          if (m_dwell < SD - 1) m_dwell++;
          else begin
            m_dwell = 0;
            if (zeros == 1) begin
              m_pat = rows_n; m_row = idx; m_stable = 0; m_mode = 1;
            end else m_col = (m_col + 1) % 4;
          end
        end
        1: begin
          if (m_stable == DB) begin
            m_valid = 1; m_code = 4'(m_row * 4 + m_col); m_held = 1; m_mode = 2;
          end else if (rows_n == m_pat) m_stable++;
          else begin m_mode = 0; m_dwell = 0; end
        end
        2: if (rows_n[m_row]) begin m_mode = 3; m_stable = 0; end
        default: begin
          if (!rows_n[m_row]) m_mode = 2;
          else if (m_stable == DB) begin
            m_held = 0; m_col = (m_col + 1) % 4; m_dwell = 0; m_mode = 0;
          end else m_stable++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_cols_n", cols_n, ~(4'b0001 << m_col));
      check("model_key_code", key_code, m_code);
      check("model_key_valid", {3'b000, key_valid}, {3'b000, m_valid});
      check("model_key_held", {3'b000, key_held}, {3'b000, m_held});
    end
  end

  task automatic step(input logic [3:0] r, input logic rst);
    rows_n = r;
    reset = rst;
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic wait_cols(input logic [3:0] target, input int budget);
    int k;
    k = 0;
    while (cols_n !== target && k < budget) begin
      step(4'hF, 1'b1);
      k++;
    end
    check("wait_cols", cols_n, target);
  endtask

  logic [3:0] col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int at_step;

    // Reset
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    check("rst_cols_n", cols_n, 4'b1110);
    check("rst_key_code", key_code, 4'b0000);
    check("rst_key_valid", {3'b000, key_valid}, 4'b0000);
    check("rst_key_held", {3'b000, key_held}, 4'b0000);

    // 1: idle scan
    for (int i = 0; i < 16; i++) begin
      step(4'hF, 1'b1);
      check("idle_cols_n", cols_n, col_seq[((i + 1) / 2) % 4]);
    end
    check_int("idle_pulses", pulses, 0);

    // 2: press row 1 on column 2
    wait_cols(4'b1011, 20);
    at_step = -1;
    for (int s = 1; s <= 12; s++) begin
      step(4'b1101, 1'b1);
      if (key_valid === 1'b1 && at_step < 0) at_step = s;
    end
    check_int("press_latency_step", at_step, 7);
    check_int("press_pulses", pulses, 1);
    check("press_key_code", key_code, 4'b0110);
    check("press_key_held", {3'b000, key_held}, 4'b0001);
    check("press_cols_frozen", cols_n, 4'b1011);

    // 5b: extra row while held is ignored
    for (int s = 0; s < 6; s++) step(4'b0101, 1'b1);
    check_int("held_other_row_pulses", pulses, 1);
    check("held_other_row_held", {3'b000, key_held}, 4'b0001);

    // 4: release with bounces
    for (int s = 0; s < 6; s++) begin
      step(4'hF, 1'b1);
      step(4'b1101, 1'b1);
    end
    for (int s = 0; s < 5; s++) begin
      step(4'hF, 1'b1);
      check("release_still_held", {3'b000, key_held}, 4'b0001);
    end
    step(4'hF, 1'b1);
    check("release_held_low", {3'b000, key_held}, 4'b0000);
    check("release_cols_n", cols_n, 4'b0111);
    check_int("release_pulses", pulses, 1);

    // 3: bouncing press never accepted, scan stays on column 2
    wait_cols(4'b1011, 20);
    for (int p = 0; p < 4; p++) begin
      step(4'b1101, 1'b1);
      step(4'b1101, 1'b1);
      step(4'hF, 1'b1);
      step(4'hF, 1'b1);
      check("bounce_cols_n", cols_n, 4'b1011);
    end
    check_int("bounce_pulses", pulses, 1);
    step(4'hF, 1'b1);
    check("bounce_resume_cols_n", cols_n, 4'b0111);

    // 5a: two rows low in SCAN is ignored
    for (int s = 0; s < 8; s++) begin
      step(4'b1001, 1'b1);
      if (s == 1) check("ambig_cols_adv", cols_n, 4'b1110);
    end
    check("ambig_cols_n", cols_n, 4'b0111);
    check("ambig_held", {3'b000, key_held}, 4'b0000);
    check_int("ambig_pulses", pulses, 1);

    // 6a: reset mid-debounce
    for (int s = 0; s < 3; s++) step(4'b0111, 1'b1);
    step(4'b0111, 1'b0);
    check("rst_db_cols_n", cols_n, 4'b1110);
    check("rst_db_key_code", key_code, 4'b0000);
    check("rst_db_key_held", {3'b000, key_held}, 4'b0000);
    check("rst_db_key_valid", {3'b000, key_valid}, 4'b0000);

    // 6b: press row 3 on column 0, then reset while held
    for (int s = 0; s < 8; s++) step(4'b0111, 1'b1);
    check("pre_rst_key_code", key_code, 4'b1100);
    check("pre_rst_key_held", {3'b000, key_held}, 4'b0001);
    check_int("pre_rst_pulses", pulses, 2);
    step(4'b0111, 1'b0);
    check("rst_held_cols_n", cols_n, 4'b1110);
    check("rst_held_key_code", key_code, 4'b0000);
    check("rst_held_key_held", {3'b000, key_held}, 4'b0000);
    check("rst_held_key_valid", {3'b000, key_valid}, 4'b0000);
    for (int s = 0; s < 4; s++) step(4'hF, 1'b1);
    check_int("final_pulses", pulses, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
